// File: rtl/wb_stage_if.sv
// MEM -> WB handoff bus: one instruction per transfer (mem_valid & mem_ready).
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result;
  logic        mem_is_load;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;

  modport master (
    output mem_valid, mem_wen, mem_waddr, mem_result, mem_is_load, mem_ld_type, mem_addr_lo,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_wen, mem_waddr, mem_result, mem_is_load, mem_ld_type, mem_addr_lo,
    output mem_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: single-entry buffer that waits for load data, extends it and drives the
// register-file write port; counts retired instructions.
module wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_stage_if.slave         mem,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  input  logic              wb_stall,
  input  logic              wb_flush,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [1:0] {StIdle, StWaitData, StReady} state_e;

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [31:0]       result_q, result_d;
  logic [2:0]        ld_type_q, ld_type_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              retire;
  logic              accept;
  logic [31:0]       ext_data;

  function automatic logic [31:0] extend(logic [2:0] ld_type, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (ld_type)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {24'd0, b};
      3'd2:    return {{16{h[15]}}, h};
      3'd3:    return {16'd0, h};
      default: return w;  // LW and reserved encodings
    endcase
  endfunction

  always_comb begin
    retire        = rst_n & ~wb_stall & ~wb_flush &
                    ((state_q == StReady) | ((state_q == StWaitData) & dmem_rvalid));
    mem.mem_ready = rst_n & ~wb_flush & ((state_q == StIdle) | retire);
    accept        = mem.mem_valid & mem.mem_ready;
    ext_data      = extend(ld_type_q, addr_lo_q, dmem_rdata);

    rf_wen   = retire & wen_q & (waddr_q != 5'd0);
    rf_waddr = waddr_q;
    // In READY, result_q already holds either the ALU result or latched, extended load data.
    rf_wdata = (state_q == StWaitData) ? ext_data : result_q;
  end

  always_comb begin
    state_d   = state_q;
    wen_d     = wen_q;
    waddr_d   = waddr_q;
    result_d  = result_q;
    ld_type_d = ld_type_q;
    addr_lo_d = addr_lo_q;
    cnt_d     = cnt_q + CNT_W'(retire);

    if (wb_flush) begin
      state_d = StIdle;
    end else if (accept) begin
      state_d   = mem.mem_is_load ? StWaitData : StReady;
      wen_d     = mem.mem_wen;
      waddr_d   = mem.mem_waddr;
      result_d  = mem.mem_result;
      ld_type_d = mem.mem_ld_type;
      addr_lo_d = mem.mem_addr_lo;
    end else if (retire) begin
      state_d = StIdle;
    end else if ((state_q == StWaitData) && dmem_rvalid) begin
      // Data arrived under stall: keep it so no second rvalid is needed.
      state_d  = StReady;
      result_d = ext_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wen_q     <= 1'b0;
      waddr_q   <= 5'd0;
      result_q  <= 32'd0;
      ld_type_q <= 3'd0;
      addr_lo_q <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      result_q  <= result_d;
      ld_type_q <= ld_type_d;
      addr_lo_q <= addr_lo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second instance with a 4-bit counter mirrors the stimulus to
// exercise counter wrap.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_stall;
  logic        wb_flush;
  logic        rf_wen, rf_wen2;
  logic [4:0]  rf_waddr, rf_waddr2;
  logic [31:0] rf_wdata, rf_wdata2;
  logic [31:0] retired_cnt;
  logic [3:0]  small_cnt;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  wb_stage_if ifc ();
  wb_stage_if ifc2 ();

  assign ifc2.mem_valid   = ifc.mem_valid;
  assign ifc2.mem_wen     = ifc.mem_wen;
  assign ifc2.mem_waddr   = ifc.mem_waddr;
  assign ifc2.mem_result  = ifc.mem_result;
  assign ifc2.mem_is_load = ifc.mem_is_load;
  assign ifc2.mem_ld_type = ifc.mem_ld_type;
  assign ifc2.mem_addr_lo = ifc.mem_addr_lo;

  wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem(ifc), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .retired_cnt(retired_cnt)
  );

  wb_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .mem(ifc2), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .rf_wen(rf_wen2), .rf_waddr(rf_waddr2),
    .rf_wdata(rf_wdata2), .retired_cnt(small_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, wen;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic        is_load;
    logic [2:0]  ld;
    logic [1:0]  a;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall, flush;
    logic        e_ready, e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic valid, logic wen, logic [4:0] waddr, logic [31:0] result,
                              logic is_load, logic [2:0] ld, logic [1:0] a, logic rvalid,
                              logic [31:0] rdata, logic stall, logic flush, logic e_ready,
                              logic e_wen, logic [4:0] e_waddr, logic [31:0] e_wdata,
                              logic [31:0] e_cnt);
    vec_t v;
    v.valid = valid; v.wen = wen; v.waddr = waddr; v.result = result; v.is_load = is_load;
    v.ld = ld; v.a = a; v.rvalid = rvalid; v.rdata = rdata; v.stall = stall; v.flush = flush;
    v.e_ready = e_ready; v.e_wen = e_wen; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic apply(string tag, vec_t v);
    logic [31:0] small_exp;
    ifc.mem_valid   = v.valid;
    ifc.mem_wen     = v.wen;
    ifc.mem_waddr   = v.waddr;
    ifc.mem_result  = v.result;
    ifc.mem_is_load = v.is_load;
    ifc.mem_ld_type = v.ld;
    ifc.mem_addr_lo = v.a;
    dmem_rvalid     = v.rvalid;
    dmem_rdata      = v.rdata;
    wb_stall        = v.stall;
    wb_flush        = v.flush;
    @(negedge clk);
    small_exp = {28'd0, v.e_cnt[3:0]};
    chk({tag, " mem_ready"}, {31'd0, ifc.mem_ready}, {31'd0, v.e_ready});
    chk({tag, " rf_wen"}, {31'd0, rf_wen}, {31'd0, v.e_wen});
    chk({tag, " retired_cnt"}, retired_cnt, v.e_cnt);
    chk({tag, " small_cnt"}, {28'd0, small_cnt}, small_exp);
    if (v.e_wen) begin
      chk({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, v.e_waddr});
      chk({tag, " rf_wdata"}, rf_wdata, v.e_wdata);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RD = 32'h80FF7F01;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //        v  w  wa  res    ld ty a rv rdata    st fl  erdy ewen ewa ewdata     ecnt
    // Back-to-back ALU ops
    tbl[0]  = mk(1, 1, 3, 32'h11, 0, 0, 0, 0, 0,  0, 0,  1, 0, 0,  0,            0);
    tbl[1]  = mk(1, 1, 4, 32'h22, 0, 0, 0, 0, 0,  0, 0,  1, 1, 3,  32'h11,       0);
    tbl[2]  = mk(1, 1, 5, 32'h33, 0, 0, 0, 0, 0,  0, 0,  1, 1, 4,  32'h22,       1);
    tbl[3]  = mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  0, 0,  1, 1, 5,  32'h33,       2);
    tbl[4]  = mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  0, 0,  1, 0, 0,  0,            3);
    // Pipelined loads, each extension type
    tbl[5]  = mk(1, 1, 6, 0,      1, 0, 3, 0, 0,  0, 0,  1, 0, 0,  0,            3);
    tbl[6]  = mk(1, 1, 7, 0,      1, 1, 1, 1, RD, 0, 0,  1, 1, 6,  32'hFFFFFF80, 3);
    tbl[7]  = mk(1, 1, 8, 0,      1, 2, 2, 1, RD, 0, 0,  1, 1, 7,  32'h0000007F, 4);
    tbl[8]  = mk(1, 1, 9, 0,      1, 3, 0, 1, RD, 0, 0,  1, 1, 8,  32'hFFFF80FF, 5);
    tbl[9]  = mk(1, 1, 10, 0,     1, 4, 3, 1, RD, 0, 0,  1, 1, 9,  32'h00007F01, 6);
    tbl[10] = mk(0, 0, 0, 0,      0, 0, 0, 1, RD, 0, 0,  1, 1, 10, 32'h80FF7F01, 7);
    // Reserved load type behaves as LW
    tbl[11] = mk(1, 1, 11, 0,     1, 7, 1, 0, 0,  0, 0,  1, 0, 0,  0,            8);
    tbl[12] = mk(0, 0, 0, 0,      0, 0, 0, 1, 32'h12345678, 0, 0, 1, 1, 11, 32'h12345678, 8);
    tbl[13] = mk(0, 0, 0, 0,      0, 0, 0, 0, 0,  0, 0,  1, 0, 0,  0,            9);

    ifc.mem_valid = 0; ifc.mem_wen = 0; ifc.mem_waddr = 0; ifc.mem_result = 0;
    ifc.mem_is_load = 0; ifc.mem_ld_type = 0; ifc.mem_addr_lo = 0;
    dmem_rvalid = 0; dmem_rdata = 0; wb_stall = 0; wb_flush = 0;
    rst_n = 0;
    ifc.mem_valid = 1;  // must be refused while in reset
    @(posedge clk);
    @(negedge clk);
    chk("reset mem_ready", {31'd0, ifc.mem_ready}, 32'd0);
    chk("reset rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("reset retired_cnt", retired_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;

    for (int i = 0; i < 14; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Late rvalid: stage stalls upstream until data arrives
    apply("late0", mk(1, 1, 12, 0,     1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 9));
    apply("late1", mk(1, 1, 13, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
    apply("late2", mk(1, 1, 13, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
    apply("late3", mk(1, 1, 13, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
    apply("late4", mk(1, 1, 13, 32'h55, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 1, 1, 12, 32'hCAFEF00D, 9));
    apply("late5", mk(0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 1, 13, 32'h55, 10));
    apply("late6", mk(0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 11));

    // rvalid under stall: data latched, released two cycles later
    apply("stl0", mk(1, 1, 14, 0, 1, 2, 2, 0, 0,  0, 0, 1, 0, 0,  0, 11));
    apply("stl1", mk(0, 0, 0, 0,  0, 0, 0, 1, RD, 1, 0, 0, 0, 0,  0, 11));
    apply("stl2", mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 11));
    apply("stl3", mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 11));
    apply("stl4", mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 14, 32'hFFFF80FF, 11));
    apply("stl5", mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 12));

    // Flush drops held load and refuses the same-cycle transfer; x0 write retires silently
    apply("fl0", mk(1, 1, 15, 0,      1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 12));
    apply("fl1", mk(1, 1, 16, 32'h66, 0, 0, 0, 1, RD, 1, 1, 0, 0, 0, 0, 12));
    apply("fl2", mk(0, 0, 0, 0,       0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 12));
    apply("fl3", mk(1, 1, 0, 32'h77,  0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 12));
    apply("fl4", mk(0, 0, 0, 0,       0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 12));
    apply("fl5", mk(0, 0, 0, 0,       0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 13));

    // Reset while waiting for load data
    apply("rst0", mk(1, 1, 17, 0, 1, 4, 0, 0, 0,  0, 0, 1, 0, 0, 0, 13));
    rst_n = 0;
    apply("rst1", mk(0, 0, 0, 0,  0, 0, 0, 1, RD, 0, 0, 0, 0, 0, 0, 13));
    rst_n = 1;
    apply("rst2", mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0));

    // Sixteen back-to-back retires: 4-bit counter wraps to 0
    for (int i = 0; i < 18; i++) begin
      apply($sformatf("wrap%0d", i),
            mk(i < 16, 1, 1, 32'(i), 0, 0, 0, 0, 0, 0, 0, 1, (i >= 1) && (i <= 16), 1,
               32'(i - 1), (i == 0) ? 32'd0 : 32'(i - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
